// File: rtl/accel_fmt_pkg.sv
// Shared types and constants for the accelerometer ASCII frame formatter.
// Axis labels are enabled by the ACCEL_FMT_AXIS_LABEL_EN macro in the top level.
package accel_fmt_pkg;

  localparam int unsigned AXIS_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [BYTE_W-1:0] ASCII_SEP    = 8'h20;
  localparam logic [BYTE_W-1:0] ASCII_CR     = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF     = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_EQ     = 8'h3D;
  localparam logic [BYTE_W-1:0] ASCII_X      = 8'h58;
  localparam logic [BYTE_W-1:0] ASCII_Y      = 8'h59;
  localparam logic [BYTE_W-1:0] ASCII_Z      = 8'h5A;
  localparam logic [BYTE_W-1:0] ASCII_DIGIT0 = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_ALPHA  = 8'h41;

  localparam int unsigned FRAME_LEN_BASE  = 16;
  localparam int unsigned FRAME_LEN_LABEL = 22;

  // One captured accelerometer sample.
  typedef struct packed {
    logic [AXIS_W-1:0] x;
    logic [AXIS_W-1:0] y;
    logic [AXIS_W-1:0] z;
  } sample_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase hex ASCII character.
module nibble_to_ascii
  import accel_fmt_pkg::*;
(
  input  logic [NIB_W-1:0]  nibble,
  output logic [BYTE_W-1:0] ascii_c
);

  always_comb begin
    if (nibble < NIB_W'(10)) begin
      ascii_c = ASCII_DIGIT0 + BYTE_W'(nibble);
    end else begin
      ascii_c = ASCII_ALPHA + BYTE_W'(nibble) - BYTE_W'(10);
    end
  end

endmodule

// File: rtl/accel_ascii_formatter.sv
// Formats one X/Y/Z accelerometer sample as a hex ASCII line and streams it to a UART.
// Define ACCEL_FMT_AXIS_LABEL_EN to prefix each axis with "X=", "Y=", "Z=".
module accel_ascii_formatter
  import accel_fmt_pkg::*;
#(
  parameter logic [7:0] X_SEP   = ASCII_SEP,
  parameter logic [7:0] TERM_CR = ASCII_CR,
  parameter logic [7:0] TERM_LF = ASCII_LF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [AXIS_W-1:0] x_data,
  input  logic [AXIS_W-1:0] y_data,
  input  logic [AXIS_W-1:0] z_data,
  output logic              sample_ready,
  output logic              tx_enable,
  output logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_complete,
  output logic              frame_done,
  output logic              sample_dropped
);

`ifdef ACCEL_FMT_AXIS_LABEL_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_LABEL;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx, idx_next;
  sample_t           data_q, data_n, sample_in_c;

  logic              slot_is_nib_c;
  logic [BYTE_W-1:0] slot_lit_c;
  logic [AXIS_W-1:0] slot_word_c;
  logic [1:0]        slot_pos_c;
  logic [NIB_W-1:0]  nib_c;
  logic [BYTE_W-1:0] nib_ascii_c;
  logic [BYTE_W-1:0] byte_c;

  assign sample_in_c = '{x: x_data, y: y_data, z: z_data};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, index and capture logic.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    data_n     = data_q;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          data_n     = sample_in_c;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: state_next = WAIT;
      WAIT: begin
        if (tx_complete) begin
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = SEND;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame layout: which byte slot is a literal and which is a hex nibble of an axis.
  always_comb begin
    slot_is_nib_c = 1'b0;
    slot_lit_c    = TERM_LF;
    slot_word_c   = data_n.x;
    slot_pos_c    = '0;
    case (idx_next) inside
`ifdef ACCEL_FMT_AXIS_LABEL_EN
      5'd0:  slot_lit_c = ASCII_X;
      5'd1:  slot_lit_c = ASCII_EQ;
      [5'd2:5'd5]: begin
        slot_is_nib_c = 1'b1;
        slot_word_c   = data_n.x;
        slot_pos_c    = 2'(idx_next - 5'd2);
      end
      5'd6:  slot_lit_c = X_SEP;
      5'd7:  slot_lit_c = ASCII_Y;
      5'd8:  slot_lit_c = ASCII_EQ;
      [5'd9:5'd12]: begin
        slot_is_nib_c = 1'b1;
        slot_word_c   = data_n.y;
        slot_pos_c    = 2'(idx_next - 5'd9);
      end
      5'd13: slot_lit_c = X_SEP;
      5'd14: slot_lit_c = ASCII_Z;
      5'd15: slot_lit_c = ASCII_EQ;
      [5'd16:5'd19]: begin
        slot_is_nib_c = 1'b1;
        slot_word_c   = data_n.z;
        slot_pos_c    = 2'(idx_next - 5'd16);
      end
      5'd20: slot_lit_c = TERM_CR;
      5'd21: slot_lit_c = TERM_LF;
`else
      [5'd0:5'd3]: begin
        slot_is_nib_c = 1'b1;
        slot_word_c   = data_n.x;
        slot_pos_c    = 2'(idx_next);
      end
      5'd4:  slot_lit_c = X_SEP;
      [5'd5:5'd8]: begin
        slot_is_nib_c = 1'b1;
        slot_word_c   = data_n.y;
        slot_pos_c    = 2'(idx_next - 5'd5);
      end
      5'd9:  slot_lit_c = X_SEP;
      [5'd10:5'd13]: begin
        slot_is_nib_c = 1'b1;
        slot_word_c   = data_n.z;
        slot_pos_c    = 2'(idx_next - 5'd10);
      end
      5'd14: slot_lit_c = TERM_CR;
      5'd15: slot_lit_c = TERM_LF;
`endif
      default: slot_lit_c = TERM_LF;
    endcase
  end

  // Most significant nibble goes out first.
  always_comb begin
    case (slot_pos_c)
      2'd0:    nib_c = slot_word_c[15:12];
      2'd1:    nib_c = slot_word_c[11:8];
      2'd2:    nib_c = slot_word_c[7:4];
      default: nib_c = slot_word_c[3:0];
    endcase
  end

  nibble_to_ascii u_nibble_to_ascii (
    .nibble  (nib_c),
    .ascii_c (nib_ascii_c)
  );

  assign byte_c = slot_is_nib_c ? nib_ascii_c : slot_lit_c;

  // Datapath and registered outputs; tx_byte only loads on entry to SEND so it
  // stays stable until the transmitter reports completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= '0;
      data_q         <= '0;
      tx_enable      <= 1'b0;
      tx_byte        <= '0;
      frame_done     <= 1'b0;
      sample_dropped <= 1'b0;
      sample_ready   <= 1'b1;
    end else begin
      idx            <= idx_next;
      data_q         <= data_n;
      tx_enable      <= (state_next == SEND);
      if (state_next == SEND) begin
        tx_byte <= byte_c;
      end
      frame_done     <= (state_next == DONE);
      sample_dropped <= sample_valid && (state != IDLE);
      sample_ready   <= (state_next == IDLE);
    end
  end

endmodule

// File: doc/accel_ascii_formatter.md
ACCEL_ASCII_FORMATTER -- requirements
Module: accel_ascii_formatter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe; x/y/z are valid this cycle
- x_data  in  16  accelerometer X sample
- y_data  in  16  accelerometer Y sample
- z_data  in  16  accelerometer Z sample
- sample_ready  out  1  high when in IDLE; a sample will be accepted
- tx_enable  out  1  one-cycle request pulse to the UART transmitter
- tx_byte  out  8  ASCII byte for the UART transmitter
- tx_complete  in  1  one-cycle pulse from the UART transmitter at end of stop bit
- frame_done  out  1  one-cycle pulse after the last byte of a frame completes
- sample_dropped  out  1  one-cycle pulse when sample_valid arrives while not ready
REQ-003 The block SHALL have these parameters:
- X_SEP, default 8'h20, separator byte between axes
- TERM_CR, default 8'h0D, first terminator byte
- TERM_LF, default 8'h0A, second terminator byte

Function
REQ-004 The frame SHALL be, in order: 4 uppercase hex chars of X (MSB nibble first), X_SEP, 4 hex chars of Y, X_SEP, 4 hex chars of Z, TERM_CR, TERM_LF. The base frame is 16 bytes.
REQ-005 Nibble encoding SHALL be 0-9 -> 8'h30-8'h39 and A-F -> 8'h41-8'h46.
REQ-006 The FSM SHALL have these states: IDLE, SEND, WAIT, DONE.
REQ-007 IDLE SHALL hold sample_ready=1. When sample_valid=1, it SHALL capture x/y/z into internal registers, clear the byte index to 0 and go to SEND on the next edge.
REQ-008 SEND SHALL drive tx_enable=1 for exactly one cycle, with tx_byte set to the byte at the current index, and then go to WAIT.
REQ-009 tx_byte SHALL remain stable from the SEND cycle until tx_complete is received, because the transmitter samples it one cycle after the request.
REQ-010 WAIT SHALL hold tx_enable=0. On tx_complete=1:
- if the index is the last index, go to DONE;
- otherwise increment the index and go to SEND.
REQ-011 DONE SHALL pulse frame_done=1 for one cycle and return to IDLE.
REQ-012 Latency SHALL be as follows: sample accepted at edge N; first tx_enable visible in cycle N+1; frame_done one cycle after the final tx_complete.
REQ-013 When sample_valid=1 and the state is not IDLE, the sample SHALL be ignored and sample_dropped SHALL pulse for one cycle. The captured data SHALL be unchanged.
REQ-014 tx_complete received in IDLE, SEND or DONE SHALL be ignored.
REQ-015 The byte index SHALL be 5 bits wide and SHALL never exceed the last index. It SHALL not wrap within a frame.
REQ-016 Back-to-back samples SHALL be accepted as follows: a sample_valid arriving in the same cycle as DONE is dropped; a sample_valid arriving in the first IDLE cycle is accepted.

Reset
REQ-017 Asserting rst_n=0 SHALL immediately force state=IDLE, index=0, captured data=0, tx_enable=0, tx_byte=8'h00, frame_done=0 and sample_dropped=0.
REQ-018 sample_ready SHALL be 1 during reset.
REQ-019 Reset asserted mid-frame SHALL abort the frame without emitting frame_done. A tx_complete pulse arriving after reset release SHALL be ignored.

Configuration
REQ-020 The macro ACCEL_FMT_AXIS_LABEL_EN SHALL control axis labels.
- When it is defined, each axis SHALL be prefixed by its label and '=' (8'h58/8'h59/8'h5A, then 8'h3D). The frame becomes 22 bytes and the last index is 21.
- When it is undefined, the frame SHALL be 16 bytes with last index 15, and no label logic SHALL be present.

Structure
REQ-021 The shared package accel_fmt_pkg SHALL hold:
- the FSM state encoding;
- ASCII constants: separator, CR, LF, '=', labels;
- frame-length constants for both configurations.
REQ-022 Nibble-to-ASCII conversion SHALL be a combinational sub-module, nibble_to_ascii (4-bit in, 8-bit out), instantiated once and fed by an index-selected nibble mux.

Verification
REQ-023 The bench SHALL use a UART transmitter model that responds with tx_complete 20 cycles after each tx_enable, and SHALL cover these scenarios:
- X=16'h1A2B, Y=16'h00FF, Z=16'hFFFF, macro off -> bytes 31 41 32 42 20 30 30 46 46 20 46 46 46 46 0D 0A, then one frame_done pulse.
- Same sample, macro on -> 58 3D 31 41 32 42 20 59 3D 30 30 46 46 20 5A 3D 46 46 46 46 0D 0A, 22 tx_enable pulses.
- sample_valid during WAIT of byte 3 -> sample_dropped pulses once; the frame continues with the original data.
- rst_n low for 2 cycles during byte 7 -> tx_enable=0 and sample_ready=1 immediately; no frame_done; a new sample after release restarts at byte 0.
- Spurious tx_complete in IDLE -> no tx_enable and no state change.
- X=Y=Z=16'h0000, macro off, samples 1 cycle after each frame_done -> continuous frames of 30 30 30 30 20 ... 0D 0A, none dropped.
